// File: rtl/hazard_pkg.sv
// Shared decode constants and instruction classes
// for the ID-stage hazard scoreboard.
package hazard_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    CL_NONE,
    CL_ALU,
    CL_LOAD,
    CL_MUL,
    CL_DIV
  } iclass_t;

endpackage

// File: rtl/hz_decode.sv
// Combinational RV32 operand/class decode for the hazard scoreboard.
// in: id_instr; out: rs1/rs2/rd, use_rs1/use_rs2/wr_rd, is_ctl, iclass.
module hz_decode
  import hazard_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic [31:0]     id_instr,
  output logic [REGW-1:0] rs1,
  output logic [REGW-1:0] rs2,
  output logic [REGW-1:0] rd,
  output logic            use_rs1,
  output logic            use_rs2,
  output logic            wr_rd,
  output logic            is_ctl,
  output iclass_t         iclass
);

  logic [6:0] opc;
  logic       muldiv;
  logic       is_div;
  logic       unused_f3;

  assign opc       = id_instr[6:0];
  assign rd        = REGW'(id_instr[11:7]);
  assign rs1       = REGW'(id_instr[19:15]);
  assign rs2       = REGW'(id_instr[24:20]);
  assign muldiv    = id_instr[31:25] == F7_MULDIV;
  assign is_div    = id_instr[14];
  assign unused_f3 = ^id_instr[13:12];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    is_ctl  = 1'b0;
    iclass  = CL_NONE;
    unique case (1'b1)
      opc == OP_LOAD: begin
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
        iclass  = CL_LOAD;
      end
      opc == OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      opc == OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        is_ctl  = 1'b1;
      end
      opc == OP_JALR: begin
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
        is_ctl  = 1'b1;
        iclass  = CL_ALU;
      end
      opc == OP_JAL,
      opc == OP_LUI,
      opc == OP_AUIPC: begin
        wr_rd  = 1'b1;
        iclass = CL_ALU;
      end
      opc == OP_IMM: begin
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
        iclass  = CL_ALU;
      end
      opc == OP_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        wr_rd   = 1'b1;
        if (!muldiv)
          iclass = CL_ALU;
        else if (is_div)
          iclass = CL_DIV;
        else
          iclass = CL_MUL;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard producing the ID stall.
// in: clk, rst_n, id_valid, id_instr, pipe_hold, div_done
// out: id_stall, stall_cause {div,waw,raw}, busy_vec, stall_cnt
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int REGW     = 5,
  parameter int LAT_ALU  = 1,
  parameter int LAT_LOAD = 2,
  parameter int LAT_MUL  = 3,
  parameter int CNTW     = 3,
  parameter int PCW      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic            pipe_hold,
  input  logic            div_done,
  output logic            id_stall,
  output logic [2:0]      stall_cause,
  output logic [NREG-1:0] busy_vec,
  output logic [PCW-1:0]  stall_cnt
);

  logic [NREG-1:0][CNTW-1:0] cnt;
  logic [NREG-1:0]           dpend;
  logic                      div_busy;
  logic [REGW-1:0]           div_rd;

  logic [REGW-1:0] rs1, rs2, rd;
  logic            use_rs1, use_rs2;
  logic            wr_rd, is_ctl;
  iclass_t         iclass;

  hz_decode #(.REGW(REGW)) u_dec (
    .id_instr (id_instr),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .use_rs1  (use_rs1),
    .use_rs2  (use_rs2),
    .wr_rd    (wr_rd),
    .is_ctl   (is_ctl),
    .iclass   (iclass)
  );

  logic [CNTW-1:0] new_lat;
  logic            rdy1, rdy2;
  logic            wr_ok;
  logic            raw, waw, sdiv;
  logic            issue;

  // Divide latency is unbounded: it never waits on an
  // older countdown, dpend tracks its own completion.
  always_comb begin
    new_lat = '1;
    unique case (iclass)
      CL_ALU:  new_lat = CNTW'(LAT_ALU);
      CL_LOAD: new_lat = CNTW'(LAT_LOAD);
      CL_MUL:  new_lat = CNTW'(LAT_MUL);
      default: new_lat = '1;
    endcase
  end

  // Branch/JALR compare in ID and need the value now;
  // everyone else can take it off the EX forward path.
  assign rdy1 = !use_rs1 || rs1 == '0 ||
                (!dpend[rs1] &&
                 (is_ctl ? cnt[rs1] == '0
                         : cnt[rs1] <= CNTW'(1)));
  assign rdy2 = !use_rs2 || rs2 == '0 ||
                (!dpend[rs2] &&
                 (is_ctl ? cnt[rs2] == '0
                         : cnt[rs2] <= CNTW'(1)));

  assign wr_ok = wr_rd && rd != '0;
  assign raw   = id_valid && !(rdy1 && rdy2);
  assign waw   = id_valid && wr_ok &&
                 (dpend[rd] || cnt[rd] > new_lat);
  assign sdiv  = id_valid && iclass == CL_DIV &&
                 div_busy;

  assign id_stall = raw | waw | sdiv;
  assign issue    = id_valid && !id_stall &&
                    !pipe_hold && wr_ok;

  always_comb begin
    stall_cause = 3'b000;
    if (raw)
      stall_cause = 3'b001;
    else if (waw)
      stall_cause = 3'b010;
    else if (sdiv)
      stall_cause = 3'b100;
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < NREG; r++)
      busy_vec[r] = (cnt[r] != '0) | dpend[r];
  end

  // Later assignments win: an issue overrides both the
  // decrement and a same-cycle divide completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dpend    <= '0;
      div_busy <= 1'b0;
      div_rd   <= '0;
    end else begin
      if (!pipe_hold) begin
        for (int r = 0; r < NREG; r++)
          if (cnt[r] != '0)
            cnt[r] <= cnt[r] - 1'b1;
      end
      if (div_done && div_busy) begin
        dpend[div_rd] <= 1'b0;
        div_busy      <= 1'b0;
      end
      if (issue) begin
        if (iclass == CL_DIV) begin
          cnt[rd]   <= '0;
          dpend[rd] <= 1'b1;
          div_busy  <= 1'b1;
          div_rd    <= rd;
        end else begin
          cnt[rd] <= new_lat;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (id_stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed
// scenarios plus random traffic against a timestamp model.
module tb_hazard_scoreboard;

  localparam int NREG = 32;
  localparam int PCW  = 4;
  localparam int SMAX = (1 << PCW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            id_valid = 1'b0;
  logic [31:0]     id_instr = 32'h13;
  logic            pipe_hold = 1'b0;
  logic            div_done = 1'b0;
  logic            id_stall;
  logic [2:0]      stall_cause;
  logic [NREG-1:0] busy_vec;
  logic [PCW-1:0]  stall_cnt;

  hazard_scoreboard #(.PCW(PCW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .pipe_hold   (pipe_hold),
    .div_done    (div_done),
    .id_stall    (id_stall),
    .stall_cause (stall_cause),
    .busy_vec    (busy_vec),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: t counts unfrozen cycles; a result is
  // forwardable-in-cnt terms when fwd_at[r] - t reaches 0.
  int        t;
  int        fwd_at [NREG];
  bit        dp [NREG];
  bit        dbusy;
  int        drd;
  int        scnt;
  bit        e_stall;
  bit        e_issue;
  logic [2:0] e_cause;
  logic [NREG-1:0] e_busy;
  int        e_rd;
  int        e_cls;

  function automatic logic [31:0] add(int rd, int a, int b);
    return {7'd0, 5'(b), 5'(a), 3'd0, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] mul(int rd, int a, int b);
    return {7'd1, 5'(b), 5'(a), 3'd0, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] div(int rd, int a, int b);
    return {7'd1, 5'(b), 5'(a), 3'd4, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] lw(int rd, int a);
    return {12'd0, 5'(a), 3'd2, 5'(rd), 7'h03};
  endfunction
  function automatic logic [31:0] sw(int b, int a);
    return {7'd0, 5'(b), 5'(a), 3'd2, 5'd0, 7'h23};
  endfunction
  function automatic logic [31:0] beq(int a, int b);
    return {7'd0, 5'(b), 5'(a), 3'd0, 5'd0, 7'h63};
  endfunction
  function automatic logic [31:0] jalr(int rd, int a);
    return {12'd0, 5'(a), 3'd0, 5'(rd), 7'h67};
  endfunction
  function automatic logic [31:0] jal(int rd);
    return {20'd0, 5'(rd), 7'h6f};
  endfunction
  function automatic logic [31:0] lui(int rd);
    return {20'h12345, 5'(rd), 7'h37};
  endfunction
  function automatic logic [31:0] addi(int rd, int a);
    return {12'd1, 5'(a), 3'd0, 5'(rd), 7'h13};
  endfunction

  // Classes: 0 none, 1 alu, 2 load, 3 mul, 4 div
  task automatic m_decode(input logic [31:0] ins,
                          output int rs1, output int rs2,
                          output int rd, output bit u1,
                          output bit u2, output bit wr,
                          output bit ctl, output int cls);
    rs1 = int'(ins[19:15]);
    rs2 = int'(ins[24:20]);
    rd  = int'(ins[11:7]);
    u1 = 0; u2 = 0; wr = 0; ctl = 0; cls = 0;
    case (ins[6:0])
      7'h03: begin u1 = 1; wr = 1; cls = 2; end
      7'h23: begin u1 = 1; u2 = 1; end
      7'h63: begin u1 = 1; u2 = 1; ctl = 1; end
      7'h67: begin u1 = 1; wr = 1; ctl = 1; cls = 1; end
      7'h6f, 7'h37, 7'h17: begin wr = 1; cls = 1; end
      7'h13: begin u1 = 1; wr = 1; cls = 1; end
      7'h33: begin
        u1 = 1; u2 = 1; wr = 1;
        if (ins[31:25] != 7'd1) cls = 1;
        else cls = ins[14] ? 4 : 3;
      end
      default: ;
    endcase
  endtask

  function automatic int lat_of(int cls);
    return (cls == 2) ? 2 : (cls == 3) ? 3 : 1;
  endfunction

  function automatic int cnt_of(int r);
    return (fwd_at[r] > t) ? fwd_at[r] - t : 0;
  endfunction

  function automatic bit src_ok(int r, bit ctl);
    if (r == 0) return 1;
    if (dp[r]) return 0;
    return ctl ? (cnt_of(r) == 0) : (cnt_of(r) <= 1);
  endfunction

  task automatic model_clear();
    t = 0; dbusy = 0; drd = 0; scnt = 0;
    for (int r = 0; r < NREG; r++) begin
      fwd_at[r] = 0;
      dp[r] = 0;
    end
  endtask

  task automatic model_eval();
    int rs1, rs2, rd, cls;
    bit u1, u2, wr, ctl, raw, waw, sd;
    m_decode(id_instr, rs1, rs2, rd, u1, u2, wr, ctl, cls);
    raw = id_valid && ((u1 && !src_ok(rs1, ctl)) ||
                       (u2 && !src_ok(rs2, ctl)));
    waw = id_valid && wr && rd != 0 &&
          (dp[rd] || (cls != 4 && cnt_of(rd) > lat_of(cls)));
    sd = id_valid && cls == 4 && dbusy;
    e_stall = raw || waw || sd;
    e_cause = raw ? 3'b001 : waw ? 3'b010 :
              sd ? 3'b100 : 3'b000;
    e_issue = id_valid && !e_stall && !pipe_hold &&
              wr && rd != 0;
    e_rd = rd;
    e_cls = cls;
    for (int r = 0; r < NREG; r++)
      e_busy[r] = (r != 0) && (cnt_of(r) > 0 || dp[r]);
  endtask

  task automatic drive(input bit v, input logic [31:0] ins,
                       input bit h, input bit d);
    id_valid = v;
    id_instr = ins;
    pipe_hold = h;
    div_done = d;
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (div_done && dbusy) begin
      dp[drd] = 0;
      dbusy = 0;
    end
    if (e_issue) begin
      if (e_cls == 4) begin
        dp[e_rd] = 1;
        fwd_at[e_rd] = 0;
        dbusy = 1;
        drd = e_rd;
      end else begin
        fwd_at[e_rd] = t + 1 + lat_of(e_cls);
      end
    end
    if (e_stall && scnt != SMAX) scnt++;
    if (!pipe_hold) t++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    id_valid = 0; pipe_hold = 0; div_done = 0;
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 32'h13, 0, 0);
    n_chk++; if (busy_vec !== '0) begin n_fail++;
      $display("FAIL rst_busy: got %h want 0", busy_vec); end
    n_chk++; if (id_stall !== 1'b0) begin n_fail++;
      $display("FAIL rst_stall: got %b want 0", id_stall); end
    n_chk++; if (stall_cause !== 3'b000) begin n_fail++;
      $display("FAIL rst_cause: got %b want 000", stall_cause); end
    n_chk++; if (stall_cnt !== '0) begin n_fail++;
      $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_load_branch();
    drive(1, lw(5, 1), 0, 0);
    n_chk++; if (id_stall !== 1'b0) begin n_fail++;
      $display("FAIL lb_issue: got %b want 0", id_stall); end
    tick();
    drive(1, beq(5, 6), 0, 0);
    n_chk++; if (stall_cause !== 3'b001) begin n_fail++;
      $display("FAIL lb_cause: got %b want 001", stall_cause); end
    n_chk++; if (busy_vec[5] !== 1'b1) begin n_fail++;
      $display("FAIL lb_busy5: got %b want 1", busy_vec[5]); end
    tick();
    drive(1, beq(5, 6), 0, 0);
    n_chk++; if (id_stall !== 1'b1) begin n_fail++;
      $display("FAIL lb_cnt1: got %b want 1", id_stall); end
    tick();
    drive(1, beq(5, 6), 0, 0);
    n_chk++; if (id_stall !== 1'b0) begin n_fail++;
      $display("FAIL lb_go: got %b want 0", id_stall); end
    tick();
    drive(1, lw(5, 1), 0, 0);
    tick();
    drive(1, add(7, 5, 1), 0, 0);
    n_chk++; if (id_stall !== 1'b1) begin n_fail++;
      $display("FAIL lb_fwd_wait: got %b want 1", id_stall); end
    tick();
    drive(1, add(7, 5, 1), 0, 0);
    n_chk++; if (id_stall !== 1'b0) begin n_fail++;
      $display("FAIL lb_fwd_ok: got %b want 0", id_stall); end
    tick();
  endtask

  task automatic test_alu_branch();
    drive(1, add(3, 1, 2), 0, 0);
    tick();
    drive(1, beq(3, 0), 0, 0);
    n_chk++; if (stall_cause !== 3'b001) begin n_fail++;
      $display("FAIL ab_cause: got %b want 001", stall_cause); end
    tick();
    drive(1, beq(3, 0), 0, 0);
    n_chk++; if (id_stall !== 1'b0) begin n_fail++;
      $display("FAIL ab_go: got %b want 0", id_stall); end
    tick();
    drive(1, add(0, 1, 2), 0, 0);
    tick();
    drive(1, beq(0, 0), 0, 0);
    n_chk++; if (id_stall !== 1'b0) begin n_fail++;
      $display("FAIL ab_x0: got %b want 0", id_stall); end
    n_chk++; if (busy_vec !== '0) begin n_fail++;
      $display("FAIL ab_x0_busy: got %h want 0", busy_vec); end
    tick();
  endtask

  task automatic test_div();
    drive(1, div(8, 1, 2), 0, 0);
    n_chk++; if (id_stall !== 1'b0) begin n_fail++;
      $display("FAIL dv_issue: got %b want 0", id_stall); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, add(9, 8, 1), 0, 0);
      n_chk++; if (stall_cause !== 3'b001) begin n_fail++;
        $display("FAIL dv_raw%0d: got %b want 001", i, stall_cause); end
      tick();
    end
    n_chk++; if (busy_vec[8] !== 1'b1) begin n_fail++;
      $display("FAIL dv_busy8: got %b want 1", busy_vec[8]); end
    drive(1, div(10, 1, 2), 0, 0);
    n_chk++; if (stall_cause !== 3'b100) begin n_fail++;
      $display("FAIL dv_struct: got %b want 100", stall_cause); end
    tick();
    drive(1, add(9, 8, 1), 0, 1);
    n_chk++; if (id_stall !== 1'b1) begin n_fail++;
      $display("FAIL dv_done_cyc: got %b want 1", id_stall); end
    tick();
    drive(1, add(9, 8, 1), 0, 0);
    n_chk++; if (id_stall !== 1'b0) begin n_fail++;
      $display("FAIL dv_after: got %b want 0", id_stall); end
    n_chk++; if (busy_vec[8] !== 1'b0) begin n_fail++;
      $display("FAIL dv_clr8: got %b want 0", busy_vec[8]); end
    tick();
    drive(1, div(10, 1, 2), 0, 0);
    n_chk++; if (id_stall !== 1'b0) begin n_fail++;
      $display("FAIL dv_second: got %b want 0", id_stall); end
    tick();
    drive(0, 32'h13, 0, 1);
    tick();
  endtask

  task automatic test_waw();
    drive(1, mul(4, 1, 2), 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, add(4, 1, 2), 0, 0);
      n_chk++; if (stall_cause !== 3'b010) begin n_fail++;
        $display("FAIL ww_cause%0d: got %b want 010", i, stall_cause); end
      tick();
    end
    drive(1, add(4, 1, 2), 0, 0);
    n_chk++; if (id_stall !== 1'b0) begin n_fail++;
      $display("FAIL ww_go: got %b want 0", id_stall); end
    tick();
    drive(0, 32'h13, 0, 0);
    n_chk++; if (busy_vec[4] !== 1'b1) begin n_fail++;
      $display("FAIL ww_busy4: got %b want 1", busy_vec[4]); end
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    drive(1, lw(5, 1), 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h13, 1, 0);
      n_chk++; if (busy_vec[5] !== 1'b1) begin n_fail++;
        $display("FAIL hd_busy%0d: got %b want 1", i, busy_vec[5]); end
      tick();
    end
    drive(1, beq(5, 6), 1, 0);
    n_chk++; if (stall_cnt !== 4'd0) begin n_fail++;
      $display("FAIL hd_cnt0: got %0d want 0", stall_cnt); end
    tick();
    drive(1, beq(5, 6), 1, 0);
    tick();
    drive(1, beq(5, 6), 0, 0);
    n_chk++; if (stall_cnt !== 4'd2) begin n_fail++;
      $display("FAIL hd_cnt2: got %0d want 2", stall_cnt); end
    n_chk++; if (id_stall !== 1'b1) begin n_fail++;
      $display("FAIL hd_held: got %b want 1", id_stall); end
    tick();
    drive(1, beq(5, 6), 0, 0);
    tick();
    drive(1, beq(5, 6), 0, 0);
    n_chk++; if (id_stall !== 1'b0) begin n_fail++;
      $display("FAIL hd_go: got %b want 0", id_stall); end
    n_chk++; if (stall_cnt !== 4'd4) begin n_fail++;
      $display("FAIL hd_cnt4: got %0d want 4", stall_cnt); end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    drive(1, div(8, 1, 2), 0, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1, add(9, 8, 1), 0, 0);
      tick();
    end
    drive(1, add(9, 8, 1), 0, 0);
    n_chk++; if (stall_cnt !== 4'hf) begin n_fail++;
      $display("FAIL sat_cnt: got %0d want 15", stall_cnt); end
    tick();
    drive(1, add(9, 8, 1), 0, 0);
    n_chk++; if (stall_cnt !== 4'hf) begin n_fail++;
      $display("FAIL sat_hold: got %0d want 15", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    drive(1, lw(5, 1), 0, 0);
    tick();
    drive(1, beq(5, 6), 0, 0);
    #2;
    rst_n = 0;
    #1;
    n_chk++; if (busy_vec !== '0) begin n_fail++;
      $display("FAIL mr_busy: got %h want 0", busy_vec); end
    n_chk++; if (id_stall !== 1'b0) begin n_fail++;
      $display("FAIL mr_stall: got %b want 0", id_stall); end
    n_chk++; if (stall_cnt !== '0) begin n_fail++;
      $display("FAIL mr_cnt: got %0d want 0", stall_cnt); end
    @(negedge clk);
    rst_n = 1;
    model_clear();
  endtask

  function automatic logic [31:0] rand_instr();
    int a, b, c;
    a = $urandom_range(0, 7);
    b = $urandom_range(0, 7);
    c = $urandom_range(0, 7);
    case ($urandom_range(0, 9))
      0: return add(a, b, c);
      1: return lw(a, b);
      2: return sw(b, c);
      3: return beq(b, c);
      4: return jalr(a, b);
      5: return jal(a);
      6: return lui(a);
      7: return addi(a, b);
      8: return mul(a, b, c);
      default: return div(a, b, c);
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] ins;
    bit v;
    ins = rand_instr();
    for (int i = 0; i < 400; i++) begin
      if (!(e_stall && $urandom_range(0, 3) != 0))
        ins = rand_instr();
      v = $urandom_range(0, 7) != 0;
      drive(v, ins, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0);
      n_chk++; if (id_stall !== e_stall) begin n_fail++;
        $display("FAIL rnd_stall c%0d: got %b want %b", i, id_stall, e_stall); end
      n_chk++; if (stall_cause !== e_cause) begin n_fail++;
        $display("FAIL rnd_cause c%0d: got %b want %b", i, stall_cause, e_cause); end
      n_chk++; if (busy_vec !== e_busy) begin n_fail++;
        $display("FAIL rnd_busy c%0d: got %h want %h", i, busy_vec, e_busy); end
      n_chk++; if (stall_cnt !== PCW'(scnt)) begin n_fail++;
        $display("FAIL rnd_scnt c%0d: got %0d want %0d", i, stall_cnt, scnt); end
      tick();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_load_branch();
    test_alu_branch();
    test_div();
    test_waw();
    test_hold();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
